// File: rtl/servant_wb_arbiter_n_pkg.sv
// servant_wb_arbiter_n_pkg: shared arbiter state encodings and arbitration mode constants
package servant_wb_arbiter_n_pkg;
   typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_e;
   localparam int ARB_FIXED = 0;
   localparam int ARB_RR    = 1;
endpackage

// File: rtl/servant_wb_arbiter_n_picker.sv
// servant_rr_picker: combinational one-hot winner, fixed priority or round-robin from ptr+1
module servant_rr_picker #(
   parameter int N  = 3,
   parameter int PW = 2
) (
   input  logic [N-1:0]  i_req,
   input  logic [PW-1:0] i_ptr,
   input  logic          i_rr,
   output logic [N-1:0]  o_win
);
   logic [PW-1:0]  start;
   logic [2*N-1:0] rot2;
   logic [2*N-1:0] win2;
   logic [N-1:0]   rot;
   logic [N-1:0]   low;
   always_comb begin
      start = (!i_rr || i_ptr == PW'(N - 1)) ? '0 : i_ptr + 1'b1;
      // rotate so the search origin sits at bit 0, isolate lowest set bit, rotate back
      rot2  = {i_req, i_req} >> start;
      rot   = rot2[N-1:0];
      low   = rot & (~rot + 1'b1);
      win2  = {low, low} << start;
      o_win = win2[2*N-1:N];
   end
endmodule

// File: rtl/servant_wb_arbiter_n.sv
// servant_wb_arbiter_n: N-master Wishbone arbiter with registered grant and optional
// watchdog that errors out stalled transactions.
module servant_wb_arbiter_n
   import servant_wb_arbiter_n_pkg::*;
#(
   parameter int NUM_MASTERS    = 3,
   parameter int AW             = 32,
   parameter int DW             = 32,
   parameter int RR_MODE        = 0,
   parameter int TIMEOUT_CYCLES = 0
) (
   input  logic                        i_clk,
   input  logic                        i_rst_n,
   input  logic [NUM_MASTERS*AW-1:0]   i_wb_m_adr,
   input  logic [NUM_MASTERS*DW-1:0]   i_wb_m_dat,
   input  logic [NUM_MASTERS*DW/8-1:0] i_wb_m_sel,
   input  logic [NUM_MASTERS-1:0]      i_wb_m_we,
   input  logic [NUM_MASTERS-1:0]      i_wb_m_cyc,
   output logic [DW-1:0]               o_wb_m_rdt,
   output logic [NUM_MASTERS-1:0]      o_wb_m_ack,
   output logic [NUM_MASTERS-1:0]      o_wb_m_err,
   output logic [AW-1:0]               o_wb_s_adr,
   output logic [DW-1:0]               o_wb_s_dat,
   output logic [DW/8-1:0]             o_wb_s_sel,
   output logic                        o_wb_s_we,
   output logic                        o_wb_s_cyc,
   input  logic [DW-1:0]               i_wb_s_rdt,
   input  logic                        i_wb_s_ack,
   output logic [NUM_MASTERS-1:0]      o_grant
);
   localparam int PW = $clog2(NUM_MASTERS);
   localparam int SW = DW / 8;
   localparam int CW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;

   state_e                 state_q, state_d;
   logic [NUM_MASTERS-1:0] grant_q, grant_d, win;
   logic [PW-1:0]          idx_q, idx_d, ptr_q, ptr_d, win_idx;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic                   busy, timeout, done;

   servant_rr_picker #(.N(NUM_MASTERS), .PW(PW)) u_picker (
      .i_req (i_wb_m_cyc),
      .i_ptr (ptr_q),
      .i_rr  (RR_MODE == ARB_RR),
      .o_win (win)
   );

   always_comb begin
      win_idx = '0;
      for (int i = 0; i < NUM_MASTERS; i++)
         if (win[i]) win_idx = PW'(i);
      busy    = state_q == GRANT;
      // ack in the final watchdog cycle takes precedence over the error
      timeout = busy && TIMEOUT_CYCLES > 0 && cnt_q == CW'(TIMEOUT_CYCLES - 1) && !i_wb_s_ack;
      done    = i_wb_s_ack || timeout;
      state_d = state_q;
      grant_d = grant_q;
      idx_d   = idx_q;
      ptr_d   = ptr_q;
      cnt_d   = '0;
      if (!busy) begin
         if (|i_wb_m_cyc) begin
            state_d = GRANT;
            grant_d = win;
            idx_d   = win_idx;
         end
      end else if (done || !i_wb_m_cyc[idx_q]) begin
         state_d = IDLE;
         grant_d = '0;
         ptr_d   = (done && RR_MODE == ARB_RR) ? idx_q : ptr_q;
      end else begin
         cnt_d = TIMEOUT_CYCLES > 0 ? cnt_q + 1'b1 : '0;
      end
      o_wb_m_rdt = i_wb_s_rdt;
      o_wb_s_adr = busy ? i_wb_m_adr[idx_q*AW +: AW] : '0;
      o_wb_s_dat = busy ? i_wb_m_dat[idx_q*DW +: DW] : '0;
      o_wb_s_sel = busy ? i_wb_m_sel[idx_q*SW +: SW] : '0;
      o_wb_s_we  = busy && i_wb_m_we[idx_q];
      o_wb_s_cyc = busy && i_wb_m_cyc[idx_q] && !timeout;
      o_wb_m_ack = (busy && i_wb_s_ack) ? NUM_MASTERS'(1) << idx_q : '0;
      o_wb_m_err = timeout ? NUM_MASTERS'(1) << idx_q : '0;
      o_grant    = grant_q;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= IDLE;
         grant_q <= '0;
         idx_q   <= '0;
         ptr_q   <= PW'(NUM_MASTERS - 1);
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         idx_q   <= idx_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
      end
   end
endmodule

// File: tb/tb_servant_wb_arbiter_n.sv
// tb_servant_wb_arbiter_n: directed checks of a fixed-priority instance and a
// round-robin instance with a 4-cycle watchdog, both driven by shared stimulus.
module tb_servant_wb_arbiter_n;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [95:0] m_adr, m_dat;
   logic [11:0] m_sel;
   logic [2:0]  m_we, m_cyc;
   logic [31:0] s_rdt;
   logic        s_ack;

   logic [31:0] f_rdt, f_s_adr, f_s_dat, r_rdt, r_s_adr, r_s_dat;
   logic [3:0]  f_s_sel, r_s_sel;
   logic [2:0]  f_ack, f_err, f_grant, r_ack, r_err, r_grant;
   logic        f_s_we, f_s_cyc, r_s_we, r_s_cyc;

   int vecs = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   servant_wb_arbiter_n #(.NUM_MASTERS(3), .RR_MODE(0), .TIMEOUT_CYCLES(0)) dut_f (
      .i_clk(clk), .i_rst_n(rst_n), .i_wb_m_adr(m_adr), .i_wb_m_dat(m_dat),
      .i_wb_m_sel(m_sel), .i_wb_m_we(m_we), .i_wb_m_cyc(m_cyc), .o_wb_m_rdt(f_rdt),
      .o_wb_m_ack(f_ack), .o_wb_m_err(f_err), .o_wb_s_adr(f_s_adr), .o_wb_s_dat(f_s_dat),
      .o_wb_s_sel(f_s_sel), .o_wb_s_we(f_s_we), .o_wb_s_cyc(f_s_cyc), .i_wb_s_rdt(s_rdt),
      .i_wb_s_ack(s_ack), .o_grant(f_grant)
   );

   servant_wb_arbiter_n #(.NUM_MASTERS(3), .RR_MODE(1), .TIMEOUT_CYCLES(4)) dut_r (
      .i_clk(clk), .i_rst_n(rst_n), .i_wb_m_adr(m_adr), .i_wb_m_dat(m_dat),
      .i_wb_m_sel(m_sel), .i_wb_m_we(m_we), .i_wb_m_cyc(m_cyc), .o_wb_m_rdt(r_rdt),
      .o_wb_m_ack(r_ack), .o_wb_m_err(r_err), .o_wb_s_adr(r_s_adr), .o_wb_s_dat(r_s_dat),
      .o_wb_s_sel(r_s_sel), .o_wb_s_we(r_s_we), .o_wb_s_cyc(r_s_cyc), .i_wb_s_rdt(s_rdt),
      .i_wb_s_ack(s_ack), .o_grant(r_grant)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vecs++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [2:0] e;
      rst_n = 1'b0;
      m_adr = {32'h2000_0200, 32'h2000_0100, 32'h2000_0000};
      m_dat = {32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
      m_sel = 12'h3C1;
      m_we  = 3'b000;
      m_cyc = 3'b000;
      s_rdt = 32'h0;
      s_ack = 1'b0;
      tick;
      tick;
      chk("rst_f_cyc", f_s_cyc, 0);
      chk("rst_f_grant", f_grant, 0);
      chk("rst_f_ack", f_ack, 0);
      chk("rst_r_grant", r_grant, 0);
      chk("rst_r_err", r_err, 0);
      // fixed priority: all request together
      rst_n = 1'b1;
      m_cyc = 3'b111;
      #1;
      chk("fp_latency_idle", f_s_cyc, 0);
      tick;
      chk("fp_g0_cyc", f_s_cyc, 1);
      chk("fp_g0_adr", f_s_adr, 32'h2000_0000);
      chk("fp_g0_grant", f_grant, 3'b001);
      chk("fp_g0_sel", f_s_sel, 4'h1);
      s_ack = 1'b1;
      #1;
      chk("fp_g0_ack", f_ack, 3'b001);
      tick;
      s_ack = 1'b0;
      m_cyc = 3'b110;
      #1;
      chk("fp_gap_cyc", f_s_cyc, 0);
      chk("fp_gap_grant", f_grant, 0);
      tick;
      chk("fp_g1_grant", f_grant, 3'b010);
      chk("fp_g1_adr", f_s_adr, 32'h2000_0100);
      s_rdt = 32'hDEAD_BEEF;
      s_ack = 1'b1;
      #1;
      chk("iso_ack", f_ack, 3'b010);
      chk("iso_rdt", f_rdt, 32'hDEAD_BEEF);
      tick;
      s_ack = 1'b0;
      m_cyc = 3'b100;
      m_we  = 3'b100;
      tick;
      chk("fp_g2_grant", f_grant, 3'b100);
      chk("fp_g2_we", f_s_we, 1);
      chk("fp_g2_dat", f_s_dat, 32'hCCCC_0002);
      s_ack = 1'b1;
      #1;
      chk("fp_g2_ack", f_ack, 3'b100);
      tick;
      s_ack = 1'b0;
      m_cyc = 3'b000;
      m_we  = 3'b000;
      tick;
      // round-robin: all masters hold cyc continuously
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      m_cyc = 3'b111;
      for (int i = 0; i < 6; i++) begin
         e = 3'b001 << (i % 3);
         tick;
         chk("rr_grant", r_grant, e);
         chk("rr_adr", r_s_adr, 32'h2000_0000 + 32'(i % 3) * 32'h100);
         s_ack = 1'b1;
         #1;
         chk("rr_ack", r_ack, e);
         tick;
         s_ack = 1'b0;
         #1;
         chk("rr_gap_grant", r_grant, 0);
      end
      m_cyc = 3'b000;
      tick;
      // watchdog: slave never acks master 0
      m_cyc = 3'b001;
      tick;
      chk("wd_c1_cyc", r_s_cyc, 1);
      chk("wd_c1_err", r_err, 0);
      tick;
      chk("wd_c2_ack", r_ack, 0);
      tick;
      chk("wd_c3_err", r_err, 0);
      tick;
      chk("wd_c4_err", r_err, 3'b001);
      chk("wd_c4_cyc", r_s_cyc, 0);
      chk("wd_c4_ack", r_ack, 0);
      m_cyc = 3'b000;
      tick;
      chk("wd_idle_grant", r_grant, 0);
      chk("wd_idle_err", r_err, 0);
      // watchdog: ack exactly on the 4th grant cycle wins
      m_cyc = 3'b001;
      tick;
      tick;
      tick;
      tick;
      s_ack = 1'b1;
      #1;
      chk("wdack_ack", r_ack, 3'b001);
      chk("wdack_err", r_err, 0);
      chk("wdack_cyc", r_s_cyc, 1);
      tick;
      s_ack = 1'b0;
      m_cyc = 3'b000;
      #1;
      chk("wdack_idle", r_grant, 0);
      // reset asserted mid-write to master 2
      m_cyc = 3'b100;
      m_we  = 3'b100;
      tick;
      chk("mr_grant", r_grant, 3'b100);
      chk("mr_we", r_s_we, 1);
      s_ack = 1'b1;
      #1;
      chk("mr_ack_pre", r_ack, 3'b100);
      #1;
      rst_n = 1'b0;
      #1;
      chk("mr_cyc", r_s_cyc, 0);
      chk("mr_grant0", r_grant, 0);
      chk("mr_ack", r_ack, 0);
      s_ack = 1'b0;
      rst_n = 1'b1;
      m_cyc = 3'b111;
      m_we  = 3'b000;
      tick;
      chk("mr_rr_first", r_grant, 3'b001);
      chk("mr_fp_first", f_grant, 3'b001);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
      $finish;
   end
endmodule
